// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM initiator controller.
package sram_ctrl_pkg;

  typedef enum logic {S_INIT, S_RUN} ctrl_state_e;

  localparam int unsigned RESP_DEPTH = 2;
  localparam int unsigned RESP_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OCC_W      = RESP_CNT_W + 1;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response stream bundle between a traffic source and sram_port_ctrl.
interface sram_port_ctrl_if #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned ADDR_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [BITS-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [BITS-1:0]   resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram_resp_fifo.sv
// Small synchronous response FIFO; head is presented combinationally from storage.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [BITS-1:0]       wdata,
  input  logic                  pop,
  output logic [RESP_CNT_W-1:0] count,
  output logic [BITS-1:0]       head
);

  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);

  logic [BITS-1:0]       mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      rptr_q;
  logic [RESP_CNT_W-1:0] count_q;
  logic                  do_pop;

  assign do_pop = pop && (count_q != '0);
  assign count  = count_q;
  assign head   = mem_q[rptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + RESP_CNT_W'(1);
        2'b01:   count_q <= count_q - RESP_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // The controller's read credit must keep this from ever tripping.
  assert property (@(posedge clock) disable iff (reset)
    !(push && !do_pop && (count_q == RESP_CNT_W'(RESP_DEPTH))));

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator for a single-port SRAM macro: clears the array after reset, then
// turns a valid/ready request stream into CEB/WEB strobes with buffered reads.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BITS   = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  sram_port_ctrl_if.slave   bus,
  output logic              init_done,
  output logic              sram_CEB,
  output logic              sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [BITS-1:0]   sram_D,
  input  logic [BITS-1:0]   sram_Q
);

  ctrl_state_e           state_q;
  logic [ADDR_W-1:0]     cnt_q;
  logic                  init_done_q;
  logic                  inflight_q;

  logic [RESP_CNT_W-1:0] resp_count;
  logic [BITS-1:0]       resp_head;
  logic                  resp_avail;
  logic                  pop;
  logic [OCC_W-1:0]      occ;
  logic                  rd_credit;
  logic                  ready;
  logic                  fire;
  logic                  rd_fire;

  // Occupancy counts the read already issued to the macro, so a new read is
  // only granted when its data is guaranteed a FIFO slot.
  always_comb begin
    resp_avail = (resp_count != '0) && !reset;
    pop        = resp_avail && bus.resp_ready;
    occ        = OCC_W'(resp_count) + OCC_W'(inflight_q);
    rd_credit  = (occ - OCC_W'(pop)) < OCC_W'(RESP_DEPTH);
    ready      = (state_q == S_RUN) && !reset && (bus.req_write || rd_credit);
    fire       = bus.req_valid && ready;
    rd_fire    = fire && !bus.req_write;
  end

  always_comb begin
    sram_CEB = 1'b1;
    sram_WEB = 1'b1;
    sram_A   = '0;
    sram_D   = '0;
    if (!reset) begin
      if (state_q == S_INIT) begin
        sram_CEB = 1'b0;
        sram_WEB = 1'b0;
        sram_A   = cnt_q;
      end else begin
        sram_A   = bus.req_addr;
        sram_D   = bus.req_wdata;
        sram_CEB = !fire;
        sram_WEB = !(fire && bus.req_write);
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_avail;
  assign bus.resp_rdata = resp_head;
  assign init_done      = init_done_q && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          inflight_q <= rd_fire;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // sram_Q is only meaningful the cycle after a read strobe, which is exactly
  // when inflight_q is set.
  sram_resp_fifo #(
    .BITS (BITS)
  ) u_resp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .wdata (sram_Q),
    .pop   (pop),
    .count (resp_count),
    .head  (resp_head)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: directed scenarios plus random traffic against a
// queue/array reference model and a behavioural SRAM macro.
module tb_sram_port_ctrl;

  localparam int BITS   = 8;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_port_ctrl_if #(.BITS(BITS), .ADDR_W(ADDR_W)) bus ();

  logic              init_done;
  logic              sram_CEB;
  logic              sram_WEB;
  logic [ADDR_W-1:0] sram_A;
  logic [BITS-1:0]   sram_D;
  logic [BITS-1:0]   sram_Q;

  sram_port_ctrl #(
    .BITS   (BITS),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done),
    .sram_CEB  (sram_CEB),
    .sram_WEB  (sram_WEB),
    .sram_A    (sram_A),
    .sram_D    (sram_D),
    .sram_Q    (sram_Q)
  );

  // Macro model: random power-up contents, garbage Q on non-read cycles.
  logic [BITS-1:0] macro_mem [DEPTH];
  logic            scrambled = 1'b0;
  always @(posedge clock) begin
    if (!scrambled) begin
      for (int i = 0; i < DEPTH; i++) macro_mem[i] <= BITS'($urandom);
      scrambled <= 1'b1;
    end else if (!sram_CEB && !sram_WEB) begin
      macro_mem[sram_A] <= sram_D;
    end
    if (!sram_CEB && sram_WEB) sram_Q <= macro_mem[sram_A];
    else                       sram_Q <= BITS'($urandom);
  end

  typedef struct {
    logic [BITS-1:0] data;
    int              avail;
  } resp_t;

  logic [BITS-1:0] ref_mem [DEPTH];
  resp_t           rq [$];
  int              cyc;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset          = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_addr   = ADDR_W'($urandom);
      bus.req_wdata  = BITS'($urandom);
      bus.resp_ready = 1'b1;
      #1;
      check("rst_req_ready",  32'(bus.req_ready),  32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_init_done",  32'(init_done),      32'd0);
      check("rst_CEB",        32'(sram_CEB),       32'd1);
      check("rst_WEB",        32'(sram_WEB),       32'd1);
      check("rst_A",          32'(sram_A),         32'd0);
      check("rst_D",          32'(sram_D),         32'd0);
    end
    rq.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cyc = 0;
  endtask

  // One clock of traffic: drive, compare against the model, then advance it.
  task automatic step(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [BITS-1:0] d, input logic rr,
                      output logic rdy, output logic ceb);
    logic exp_valid;
    logic exp_pop;
    logic exp_rdy;
    logic fire;
    int   occ;
    @(negedge clock);
    reset          = 1'b0;
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.resp_ready = rr;
    #1;
    exp_valid = 1'b0;
    if (rq.size() > 0) exp_valid = (rq[0].avail <= cyc);
    exp_pop = exp_valid && rr;
    occ     = rq.size() - (exp_pop ? 1 : 0);
    exp_rdy = (cyc >= DEPTH) && (w || occ < 2);
    fire    = v && exp_rdy;
    rdy     = bus.req_ready;
    ceb     = sram_CEB;
    check("req_ready",  32'(bus.req_ready),  32'(exp_rdy));
    check("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
    if (exp_valid) check("resp_rdata", 32'(bus.resp_rdata), 32'(rq[0].data));
    check("init_done", 32'(init_done), 32'(cyc >= DEPTH));
    if (cyc < DEPTH) begin
      check("sweep_CEB", 32'(sram_CEB), 32'd0);
      check("sweep_WEB", 32'(sram_WEB), 32'd0);
      check("sweep_A",   32'(sram_A),   32'(cyc));
      check("sweep_D",   32'(sram_D),   32'd0);
    end else begin
      check("run_CEB", 32'(sram_CEB), 32'(!fire));
      check("run_WEB", 32'(sram_WEB), 32'(!(fire && w)));
      if (fire)      check("run_A", 32'(sram_A), 32'(a));
      if (fire && w) check("run_D", 32'(sram_D), 32'(d));
    end
    @(posedge clock);
    if (exp_pop) void'(rq.pop_front());
    if (fire && w) ref_mem[a] = d;
    if (fire && !w) rq.push_back('{data: ref_mem[a], avail: cyc + 2});
    cyc++;
  endtask

  initial begin
    logic            rdy;
    logic            ceb;
    int              ceb_low;
    int              drops;
    int              accepted;
    logic [BITS-1:0] wd;

    idle_inputs();
    do_reset(3);

    // Sweep: CEB low for exactly DEPTH cycles, then quiet.
    ceb_low = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);
      if (!ceb) ceb_low++;
    end
    check("sweep_len", 32'(ceb_low), 32'(DEPTH));

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, ADDR_W'($urandom), '0, 1'b1, rdy, ceb);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);

    // Write then immediate read of the same word.
    step(1'b1, 1'b1, 8'h12, 8'hA5, 1'b1, rdy, ceb);
    step(1'b1, 1'b0, 8'h12, 8'h00, 1'b1, rdy, ceb);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);

    // 16 back-to-back reads with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      wd = BITS'($urandom);
      step(1'b1, 1'b1, ADDR_W'(8'h20 + i), wd, 1'b1, rdy, ceb);
    end
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, ADDR_W'(8'h20 + i), '0, 1'b1, rdy, ceb);
      if (!rdy) drops++;
    end
    check("b2b_drops", 32'(drops), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);

    // Backpressure: only two reads get in, writes keep flowing.
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, ADDR_W'(8'h20 + i), '0, 1'b0, rdy, ceb);
      if (rdy) accepted++;
    end
    check("bp_accepted", 32'(accepted), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ADDR_W'(8'h40 + i), BITS'($urandom), 1'b0, rdy, ceb);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);

    // Random mixed traffic over a small address window to force hits.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
           BITS'($urandom), ($urandom_range(0, 3) != 0), rdy, ceb);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);

    // Reset with responses buffered and a read in flight.
    step(1'b1, 1'b1, 8'h33, 8'h5C, 1'b0, rdy, ceb);
    step(1'b1, 1'b0, 8'h33, 8'h00, 1'b0, rdy, ceb);
    step(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, rdy, ceb);
    step(1'b1, 1'b0, 8'h33, 8'h00, 1'b0, rdy, ceb);
    do_reset(2);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);
    step(1'b1, 1'b0, 8'h33, 8'h00, 1'b1, rdy, ceb);
    step(1'b1, 1'b0, 8'h12, 8'h00, 1'b1, rdy, ceb);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1, rdy, ceb);
    check("final_drained", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
